sample_unpacker: RTL and testbench

Reads the packed 16-bit sample stream that the acquisition path writes into the sample FIFO, and reconstructs per-timestep 16-bit probe vectors. It is the reader-side counterpart of the fast-clock-domain packer and is used in loopback self-test and in simulation benches to check captured data against `PROBE` stimulus. It sits on the FIFO read side with a valid/ready handshake on both input and output.

---
 rtl/sample_unpacker.sv | 135 +++++++++++++
 tb/tb_sample_unpacker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_unpacker.sv
// Reader-side unpacker for the packed sample FIFO stream.
// Collects one word per enabled channel, then replays 16 probe vectors.
module sample_unpacker (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] channel_enable,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        group_done
);

  typedef enum logic {
    COLLECT,
    EMIT
  } state_t;

  state_t      state;
  logic [15:0] store [16];
  logic [15:0] en_q;
  logic [3:0]  ch;
  logic [3:0]  idx;
  logic        started;

  logic        accept;
  logic        fire;
  logic        last_word;
  logic [3:0]  ch_next;
  logic [3:0]  ch_first;
  logic [3:0]  ch_last;

  function automatic logic [3:0] lowest_bit(
    input logic [15:0] m
  );
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] highest_bit(
    input logic [15:0] m
  );
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] next_above(
    input logic [15:0] m,
    input logic [3:0]  c
  );
    logic [3:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) r = 4'(i);
    end
    return r;
  endfunction

  assign in_ready  = (state == COLLECT) && (en_q != 16'd0);
  assign out_valid = (state == EMIT);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign ch_first  = lowest_bit(channel_enable);
  assign ch_last   = highest_bit(en_q);
  assign ch_next   = next_above(en_q, ch);
  assign last_word = (ch == ch_last);

  always_comb begin
    out_sample = 16'd0;
    for (int c = 0; c < 16; c++) begin
      out_sample[c] = (state == EMIT) && en_q[c]
                    && store[c][idx];
    end
  end

  // en_q tracks the live mask until the first word lands,
  // and is reloaded on group end so a new mask is seen at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      en_q       <= 16'd0;
      ch         <= 4'd0;
      idx        <= 4'd0;
      started    <= 1'b0;
      group_done <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        store[i] <= 16'd0;
      end
    end else begin
      group_done <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (!started && !accept) begin
            en_q <= channel_enable;
            ch   <= ch_first;
          end
          if (accept) begin
            store[ch] <= in_data;
            started   <= 1'b1;
            if (last_word) begin
              state <= EMIT;
              idx   <= 4'd0;
            end else begin
              ch <= ch_next;
            end
          end
        end
        EMIT: begin
          if (fire) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              group_done <= 1'b1;
              state      <= COLLECT;
              started    <= 1'b0;
              en_q       <= channel_enable;
              ch         <= ch_first;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_unpacker.sv
// Directed and randomized bench for sample_unpacker
// against a queue-based reference model.
module tb_sample_unpacker;

  logic        clk;
  logic        rst;
  logic [15:0] channel_enable;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        out_ready;
  logic        group_done;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  logic [15:0] gmask;
  logic [15:0] wds [16];
  logic [15:0] exp_q [$];

  sample_unpacker dut (
    .clk            (clk),
    .rst            (rst),
    .channel_enable (channel_enable),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_sample     (out_sample),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .group_done     (group_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: timestep t of a group is channel c's word bit t,
  // masked to the enabled channels.
  task automatic model_group();
    logic [15:0] v;
    for (int t = 0; t < 16; t++) begin
      v = 16'd0;
      for (int c = 0; c < 16; c++) begin
        if (gmask[c]) v[c] = wds[c][t];
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_timeout", 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic send_group(
    input int          toggle_at,
    input logic [15:0] new_mask
  );
    int n;
    channel_enable = gmask;
    repeat (2) @(negedge clk);
    n = 0;
    for (int c = 0; c < 16; c++) begin
      if (gmask[c]) begin
        send(wds[c]);
        n++;
        if (n == toggle_at) channel_enable = new_mask;
      end
    end
    chk("in_ready_drop", 16'(in_ready), 16'd0);
    chk("emit_start", 16'(out_valid), 16'd1);
  endtask

  task automatic recv(input int nsamp);
    int n;
    logic [15:0] e;
    for (int t = 0; t < nsamp; t++) begin
      n = 0;
      out_ready = ($urandom % 3) != 0;
      while (!(out_valid && out_ready) && n < 60) begin
        @(negedge clk);
        out_ready = ($urandom % 3) != 0;
        n++;
      end
      if (!out_valid) chk("out_timeout", 16'(out_valid), 16'd1);
      e = exp_q.pop_front();
      chk($sformatf("sample_t%0d", t), out_sample, e);
      @(negedge clk);
      out_ready = 1'b0;
    end
    if (nsamp == 16) begin
      chk("group_done_pulse", 16'(group_done), 16'd1);
      chk("emit_end", 16'(out_valid), 16'd0);
      @(negedge clk);
      chk("group_done_once", 16'(group_done), 16'd0);
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic run_group();
    model_group();
    send_group(0, 16'd0);
    recv(16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0;
    fail_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    channel_enable = 16'hFFFF;
    in_data = 16'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_sample", out_sample, 16'd0);
    chk("rst_group_done", 16'(group_done), 16'd0);

    rst = 1'b0;
    chk("in_ready_first", 16'(in_ready), 16'd0);
    @(negedge clk);
    chk("in_ready_rise", 16'(in_ready), 16'd1);

    channel_enable = 16'd0;
    repeat (3) @(negedge clk);
    chk("zero_mask_ready", 16'(in_ready), 16'd0);
    chk("zero_mask_valid", 16'(out_valid), 16'd0);

    gmask = 16'hFFFF;
    for (int c = 0; c < 16; c++) wds[c] = 16'd1 << c;
    run_group();

    gmask = 16'h0020;
    for (int c = 0; c < 16; c++) wds[c] = 16'($urandom);
    wds[5] = 16'hA5A5;
    run_group();

    gmask = 16'h8001;
    wds[0] = 16'hFFFF;
    wds[15] = 16'h0000;
    run_group();

    gmask = 16'h00F0;
    for (int c = 0; c < 16; c++) wds[c] = 16'($urandom);
    run_group();

    for (int g = 0; g < 8; g++) begin
      gmask = 16'($urandom_range(1, 65535));
      for (int c = 0; c < 16; c++) wds[c] = 16'($urandom);
      run_group();
    end

    gmask = 16'h000F;
    for (int c = 0; c < 16; c++) wds[c] = 16'($urandom);
    model_group();
    send_group(2, 16'hFFFF);
    recv(16);
    gmask = 16'hFFFF;
    for (int c = 0; c < 16; c++) wds[c] = 16'($urandom);
    run_group();

    gmask = 16'h0F0F;
    for (int c = 0; c < 16; c++) wds[c] = 16'($urandom);
    model_group();
    send_group(0, 16'd0);
    recv(7);
    rst = 1'b1;
    #1;
    chk("rst_emit_valid", 16'(out_valid), 16'd0);
    chk("rst_emit_sample", out_sample, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    gmask = 16'h00FF;
    for (int c = 0; c < 16; c++) wds[c] = 16'($urandom);
    run_group();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
